// File: rtl/locked_reg_write_ctrl_if.sv
// locked_reg_write_ctrl_if: bus write and key strobes in, register-bank drive and status out
interface locked_reg_write_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int NUM_REGS = 8
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic key_valid;
  logic [DATA_W-1:0] key_data;
  logic [DATA_W-1:0] reg_data;
  logic [NUM_REGS-1:0] reg_write_en;
  logic wr_err;
  logic unlocked;
  logic lockout;
  modport master (
    output wr_valid, wr_addr, wr_data, key_valid, key_data,
    input reg_data, reg_write_en, wr_err, unlocked, lockout
  );
  modport slave (
    input wr_valid, wr_addr, wr_data, key_valid, key_data,
    output reg_data, reg_write_en, wr_err, unlocked, lockout
  );
endinterface

// File: rtl/locked_reg_write_ctrl.sv
// locked_reg_write_ctrl: two-key unlock gate for locked-register writes.
// LOCKED_REG_LOCKOUT_EN adds wrong-key counting and a timed LOCKOUT state.
module locked_reg_write_ctrl #(
  parameter int DATA_W = 16,
  parameter int NUM_REGS = 8,
  parameter logic [DATA_W-1:0] KEY0 = 16'hA5A5,
  parameter logic [DATA_W-1:0] KEY1 = 16'h5A5A,
  parameter int UNLOCK_CYCLES = 256,
  parameter int ARM_TIMEOUT = 16
`ifdef LOCKED_REG_LOCKOUT_EN
  , parameter int MAX_FAILS = 3
  , parameter int LOCKOUT_CYCLES = 1024
`endif
) (
  input logic clk,
  input logic rst,
  locked_reg_write_ctrl_if.slave bus
);
  localparam int TMAX0 = UNLOCK_CYCLES > ARM_TIMEOUT ? UNLOCK_CYCLES : ARM_TIMEOUT;
`ifdef LOCKED_REG_LOCKOUT_EN
  localparam int TMAX = TMAX0 > LOCKOUT_CYCLES ? TMAX0 : LOCKOUT_CYCLES;
`else
  localparam int TMAX = TMAX0;
`endif
  localparam int TW = $clog2(TMAX + 1);
  typedef enum logic [1:0] {S_LOCKED, S_ARMED, S_UNLOCKED, S_LOCKOUT} state_t;
  state_t state, nxt;
  logic [TW-1:0] tmr, tmr_nxt, tmr_dec;
  logic tmr_last, wr_ok;
  assign tmr_last = tmr == TW'(1);
  assign tmr_dec = tmr - TW'(1);
  assign wr_ok = bus.wr_valid && state == S_UNLOCKED && 32'(bus.wr_addr) < NUM_REGS;
`ifdef LOCKED_REG_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAILS + 1);
  logic [FW-1:0] fail_cnt;
  logic bad_key, fail_full;
  assign bad_key = bus.key_valid && ((state == S_LOCKED && bus.key_data != KEY0) ||
                                     (state == S_ARMED && bus.key_data != KEY1));
  assign fail_full = fail_cnt >= FW'(MAX_FAILS - 1);
`endif
  always_comb begin
    nxt = state;
    tmr_nxt = tmr;
    case (state)
      S_LOCKED: if (bus.key_valid && bus.key_data == KEY0) begin
        nxt = S_ARMED;
        tmr_nxt = TW'(ARM_TIMEOUT);
      end
      S_ARMED: if (bus.key_valid) begin
        nxt = bus.key_data == KEY1 ? S_UNLOCKED : S_LOCKED;
        tmr_nxt = TW'(UNLOCK_CYCLES);
      end else begin
        nxt = tmr_last ? S_LOCKED : S_ARMED;
        tmr_nxt = tmr_dec;
      end
      S_UNLOCKED: begin
        nxt = (bus.key_valid || tmr_last) ? S_LOCKED : S_UNLOCKED;
        tmr_nxt = tmr_dec;
      end
      S_LOCKOUT: begin
        nxt = tmr_last ? S_LOCKED : S_LOCKOUT;
        tmr_nxt = tmr_dec;
      end
    endcase
`ifdef LOCKED_REG_LOCKOUT_EN
    if (bad_key && fail_full) begin
      nxt = S_LOCKOUT;
      tmr_nxt = TW'(LOCKOUT_CYCLES);
    end
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_LOCKED;
      tmr <= '0;
    end else begin
      state <= nxt;
      tmr <= tmr_nxt;
    end
`ifdef LOCKED_REG_LOCKOUT_EN
  // cleared by a successful unlock or by lockout expiry; saturates on lockout entry
  always_ff @(posedge clk or posedge rst)
    if (rst) fail_cnt <= '0;
    else if ((state == S_ARMED && nxt == S_UNLOCKED) || (state == S_LOCKOUT && nxt == S_LOCKED)) fail_cnt <= '0;
    else if (bad_key) fail_cnt <= fail_full ? FW'(MAX_FAILS) : fail_cnt + FW'(1);
  assign bus.lockout = state == S_LOCKOUT;
`else
  assign bus.lockout = 1'b0;
`endif
  assign bus.unlocked = state == S_UNLOCKED;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.reg_data <= '0;
      bus.reg_write_en <= '0;
      bus.wr_err <= 1'b0;
    end else begin
      bus.reg_write_en <= wr_ok ? NUM_REGS'(1) << bus.wr_addr : '0;
      bus.wr_err <= bus.wr_valid && !wr_ok;
      if (wr_ok) bus.reg_data <= bus.wr_data;
    end
endmodule

// File: tb/tb_locked_reg_write_ctrl.sv
// tb_locked_reg_write_ctrl: directed plan plus random traffic against a countdown-based reference model
module tb_locked_reg_write_ctrl;
  localparam int DATA_W = 16;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [DATA_W-1:0] KEY0 = 16'hA5A5;
  localparam logic [DATA_W-1:0] KEY1 = 16'h5A5A;
  localparam int UNLOCK_CYCLES = 256;
  localparam int ARM_TIMEOUT = 16;
  localparam int MAX_FAILS = 3;
  localparam int LOCKOUT_CYCLES = 1024;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  int win, arm, lo, fails;
  logic [NUM_REGS-1:0] e_we;
  logic [DATA_W-1:0] e_data;
  logic e_err;
  locked_reg_write_ctrl_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) bus ();
  locked_reg_write_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    win = 0; arm = 0; lo = 0; fails = 0;
    e_we = '0; e_data = '0; e_err = 1'b0;
  endtask
  task automatic wrong_key();
`ifdef LOCKED_REG_LOCKOUT_EN
    fails++;
    if (fails >= MAX_FAILS) lo = LOCKOUT_CYCLES;
`endif
  endtask
  // remaining-cycle counters: win>0 open window, arm>0 armed, lo>0 lockout
  task automatic model_step(logic wv, logic [ADDR_W-1:0] wa, logic [DATA_W-1:0] wd, logic kv, logic [DATA_W-1:0] kd);
    bit acc;
    acc = wv && win > 0 && int'(wa) < NUM_REGS;
    e_we = '0;
    if (acc) begin e_we[wa] = 1'b1; e_data = wd; end
    e_err = wv && !acc;
    if (lo > 0) begin
      lo--;
      if (lo == 0) fails = 0;
    end else if (win > 0) win = kv ? 0 : win - 1;
    else if (arm > 0) begin
      if (!kv) arm--;
      else begin
        arm = 0;
        if (kd == KEY1) begin win = UNLOCK_CYCLES; fails = 0; end
        else wrong_key();
      end
    end else if (kv) begin
      if (kd == KEY0) arm = ARM_TIMEOUT;
      else wrong_key();
    end
  endtask
  task automatic cycle(logic wv, logic [ADDR_W-1:0] wa, logic [DATA_W-1:0] wd, logic kv, logic [DATA_W-1:0] kd);
    bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_data = wd;
    bus.key_valid = kv; bus.key_data = kd;
    @(posedge clk);
    model_step(wv, wa, wd, kv, kd);
    #1;
    check("reg_write_en", 32'(bus.reg_write_en), 32'(e_we));
    check("reg_data", 32'(bus.reg_data), 32'(e_data));
    check("wr_err", 32'(bus.wr_err), 32'(e_err));
    check("unlocked", 32'(bus.unlocked), 32'(win > 0));
    check("lockout", 32'(bus.lockout), 32'(lo > 0));
    bus.wr_valid = 1'b0; bus.key_valid = 1'b0;
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0);
  endtask
  task automatic key(logic [DATA_W-1:0] k);
    cycle(1'b0, '0, '0, 1'b1, k);
  endtask
  task automatic wr(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    cycle(1'b1, a, d, 1'b0, '0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_reg_data", 32'(bus.reg_data), 0);
    check("rst_write_en", 32'(bus.reg_write_en), 0);
    check("rst_wr_err", 32'(bus.wr_err), 0);
    check("rst_unlocked", 32'(bus.unlocked), 0);
    check("rst_lockout", 32'(bus.lockout), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    int cnt;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.key_valid = 1'b0; bus.key_data = '0;
    do_reset();
    wr(3'd2, 16'h1234);
    check("locked_wr_err", 32'(bus.wr_err), 1);
    check("locked_wr_en", 32'(bus.reg_write_en), 0);
    key(KEY0);
    key(KEY1);
    check("unlock_rise", 32'(bus.unlocked), 1);
    wr(3'd5, 16'hBEEF);
    check("beef_en", 32'(bus.reg_write_en), 32'h20);
    check("beef_data", 32'(bus.reg_data), 32'hBEEF);
    idle(1);
    check("we_one_cycle", 32'(bus.reg_write_en), 0);
    check("data_hold", 32'(bus.reg_data), 32'hBEEF);
    key(16'h0);
    check("relock", 32'(bus.unlocked), 0);
    key(KEY0);
    key(KEY1);
    cnt = 0;
    for (int i = 0; i < 400 && bus.unlocked; i++) begin cnt++; idle(1); end
    check("window_len", cnt, UNLOCK_CYCLES);
    wr(3'd1, 16'h5555);
    check("after_window_err", 32'(bus.wr_err), 1);
    key(KEY0);
    key(KEY1);
    idle(UNLOCK_CYCLES - 1);
    wr(3'd7, 16'hC0DE);
    check("last_cycle_en", 32'(bus.reg_write_en), 32'h80);
    check("last_cycle_closed", 32'(bus.unlocked), 0);
    key(16'h0);
    key(16'h0);
    key(16'h0);
`ifdef LOCKED_REG_LOCKOUT_EN
    check("lockout_rise", 32'(bus.lockout), 1);
    cnt = 1;
    key(KEY0); cnt++;
    key(KEY1); cnt++;
    check("lockout_keys_ignored", 32'(bus.unlocked), 0);
    for (int i = 0; i < 2000 && bus.lockout; i++) begin cnt++; idle(1); end
    check("lockout_len", cnt - 1, LOCKOUT_CYCLES);
`else
    check("no_lockout", 32'(bus.lockout), 0);
`endif
    key(KEY0);
    key(KEY1);
    check("unlock_after", 32'(bus.unlocked), 1);
    cycle(1'b1, 3'd3, 16'h7777, 1'b1, 16'h0);
    check("simul_en", 32'(bus.reg_write_en), 32'h08);
    check("simul_relock", 32'(bus.unlocked), 0);
    key(KEY0);
    idle(ARM_TIMEOUT - 1);
    key(KEY1);
    check("arm_last_cycle", 32'(bus.unlocked), 1);
    key(16'h0);
    key(KEY0);
    idle(ARM_TIMEOUT);
    key(KEY0);
    key(KEY1);
    check("arm_expired_rearm", 32'(bus.unlocked), 1);
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [DATA_W-1:0] kd;
      sel = $urandom_range(0, 3);
      kd = sel == 0 ? KEY0 : sel == 1 ? KEY1 : DATA_W'($urandom);
      cycle(1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom),
            $urandom_range(0, 9) == 0, kd);
    end
    idle(LOCKOUT_CYCLES + 2);
    key(KEY0);
    key(KEY1);
    idle(10);
    check("mid_window", 32'(bus.unlocked), 1);
    do_reset();
    wr(3'd4, 16'h9999);
    check("post_rst_err", 32'(bus.wr_err), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/locked_reg_write_ctrl.md
# locked_reg_write_ctrl

Key-sequence write gate that sits directly upstream of the locked-register bank and drives each register's `data_in`/`write_en` pair. It accepts bus writes and forwards them only while an unlock window is open. The window opens after a two-word key sequence and closes on timeout or an explicit relock. Repeated wrong keys put the block into a timed lockout.

## Interface
- `DATA_W`, 16, data width of bus writes and register data.
- `NUM_REGS`, 8, number of downstream locked registers; `ADDR_W = $clog2(NUM_REGS)`.
- `KEY0`, 16'hA5A5, first key word.
- `KEY1`, 16'h5A5A, second key word.
- `UNLOCK_CYCLES`, 256, unlock window length in cycles (≥1).
- `ARM_TIMEOUT`, 16, maximum number of cycles allowed in ARMED before `KEY1`.
- `MAX_FAILS`, 3, wrong-key count that triggers lockout.
- `LOCKOUT_CYCLES`, 1024, lockout duration.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  bus write request, single-cycle pulse per write.
- `wr_addr`  in  ADDR_W  target register index.
- `wr_data`  in  DATA_W  write data.
- `key_valid`  in  1  key word strobe.
- `key_data`  in  DATA_W  key word.
- `reg_data`  out  DATA_W  shared `data_in` for all registers.
- `reg_write_en`  out  NUM_REGS  one-hot `write_en`, one bit per register.
- `wr_err`  out  1  one-cycle pulse when a write is rejected.
- `unlocked`  out  1  high while the window is open.
- `lockout`  out  1  high during lockout.

## Operation
- FSM states: LOCKED, ARMED, UNLOCKED, LOCKOUT. Reset state is LOCKED.
- LOCKED:
  - `key_valid` with `KEY0` → ARMED; arm timer loads `ARM_TIMEOUT`.
  - `key_valid` with any other value → fail_cnt+1.
- ARMED:
  - `key_valid` with `KEY1` → UNLOCKED; window timer loads `UNLOCK_CYCLES`; fail_cnt clears.
  - `key_valid` with any other value → LOCKED, fail_cnt+1.
  - Arm timer expiry with no key → LOCKED, no fail counted.
- UNLOCKED:
  - The window timer decrements every cycle; when it reaches 0 → LOCKED.
  - Any `key_valid` → LOCKED (explicit relock); the key value is ignored.
- Lockout entry: when fail_cnt reaches `MAX_FAILS` → LOCKOUT; the counter loads `LOCKOUT_CYCLES`.
- LOCKOUT:
  - All keys are ignored and not counted.
  - On expiry → LOCKED with fail_cnt = 0.
- Writes:
  - A write is accepted iff state is UNLOCKED in the same cycle and `wr_addr < NUM_REGS`.
  - Accepted write: next cycle `reg_write_en` has bit `wr_addr` set and `reg_data = wr_data`, for exactly one cycle.
  - Rejected write: next cycle `wr_err`=1 for one cycle; `reg_write_en` stays 0.
- `reg_data` holds its last value when no write is accepted.
- fail_cnt saturates at `MAX_FAILS` and is never visible as a wrap.
- Simultaneous events:
  - `wr_valid` and `key_valid` in the same UNLOCKED cycle: the write is accepted, then the FSM relocks.
  - A write on the window's last cycle is accepted.

## Timing
- Reset values of all outputs: `reg_data`=0, `reg_write_en`=0, `wr_err`=0, `unlocked`=0, `lockout`=0. Reset also clears fail_cnt and all timers.
- All outputs are registered. Write latency is 1 cycle from `wr_valid` to `reg_write_en`/`wr_err`.
- `unlocked` rises the cycle after `KEY1` is accepted.
- The window spans exactly `UNLOCK_CYCLES` cycles with `unlocked`=1.
- `lockout` spans exactly `LOCKOUT_CYCLES` cycles.
- Reset asserted mid-window or mid-lockout: outputs clear immediately (asynchronously); the FSM returns to LOCKED.
- No back-pressure. Back-to-back writes every cycle are supported.

## Configuration
- `LOCKED_REG_LOCKOUT_EN` defined: fail counting and the LOCKOUT state are present as described above.
- Undefined: there is no fail counter and no LOCKOUT state. Wrong keys behave as described except no counting occurs; `lockout` is tied 0.

## Test plan
- Write 16'h1234 to addr 2 while LOCKED → `wr_err`=1 one cycle later; `reg_write_en`=0.
- Keys A5A5, 5A5A, then write 16'hBEEF to addr 5 → `unlocked`=1; next cycle `reg_write_en`=8'b0010_0000 and `reg_data`=BEEF.
- Unlock, then idle 256 cycles → `unlocked` falls after exactly 256 cycles; a write on cycle 257 → `wr_err`.
- Three wrong keys (0000) with `LOCKED_REG_LOCKOUT_EN` → `lockout`=1 for 1024 cycles. A correct key sequence sent during lockout is ignored. After expiry, the sequence unlocks.
- Key A5A5, then no key for 16 cycles → back to LOCKED with fail_cnt unchanged. Simultaneous write + key while UNLOCKED → write lands, then `unlocked`=0.
- Assert `rst` mid-window → all outputs 0 immediately; a write on the next cycle → `wr_err`.
